axi_bridge_mp: RTL and testbench

//  AXI3 master bridge between the cache subsystem and the SoC AXI bus. It replaces the fixed two-client bridge with:
//   N_RD read clients (icache, dcache, uncached/prefetch).
//   Per-client outstanding-read tracking.

---
 rtl/axi_bridge_mp.sv | 276 +++++++++++++++++++++++++++
 tb/tb_axi_bridge_mp.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_bridge_mp.sv
// rtl/axi_bridge_mp.sv - AXI3 master bridge: N read clients, round-robin AR, one-line posted write buffer
module axi_bridge_mp #(
    parameter int         N_RD       = 3,
    parameter int         LINE_WORDS = 8,
    parameter logic [3:0] WR_ID      = 4'hF
) (
    input  logic                       clk,
    input  logic                       resetn,
    output logic [3:0]                 arid,
    output logic [31:0]                araddr,
    output logic [7:0]                 arlen,
    output logic [2:0]                 arsize,
    output logic [1:0]                 arburst,
    output logic [1:0]                 arlock,
    output logic [3:0]                 arcache,
    output logic [2:0]                 arprot,
    output logic                       arvalid,
    input  logic                       arready,
    input  logic [3:0]                 rid,
    input  logic [31:0]                rdata,
    input  logic [1:0]                 rresp,
    input  logic                       rlast,
    input  logic                       rvalid,
    output logic                       rready,
    output logic [3:0]                 awid,
    output logic [31:0]                awaddr,
    output logic [7:0]                 awlen,
    output logic [2:0]                 awsize,
    output logic [1:0]                 awburst,
    output logic [1:0]                 awlock,
    output logic [3:0]                 awcache,
    output logic [2:0]                 awprot,
    output logic                       awvalid,
    input  logic                       awready,
    output logic [3:0]                 wid,
    output logic [31:0]                wdata,
    output logic [3:0]                 wstrb,
    output logic                       wlast,
    output logic                       wvalid,
    input  logic                       wready,
    input  logic [3:0]                 bid,
    input  logic [1:0]                 bresp,
    input  logic                       bvalid,
    output logic                       bready,
    input  logic [N_RD-1:0]            rd_req,
    input  logic [3*N_RD-1:0]          rd_type,
    input  logic [32*N_RD-1:0]         rd_addr,
    output logic [N_RD-1:0]            rd_rdy,
    output logic [N_RD-1:0]            ret_valid,
    output logic [N_RD-1:0]            ret_last,
    output logic [31:0]                ret_data,
    input  logic                       wr_req,
    input  logic [2:0]                 wr_type,
    input  logic [31:0]                wr_addr,
    input  logic [3:0]                 wr_wstrb,
    input  logic [32*LINE_WORDS-1:0]   wr_data,
    output logic                       wr_rdy,
    output logic                       write_buffer_empty
);

    localparam int OFFSET_W = $clog2(LINE_WORDS) + 2;
    localparam int PTR_W    = (N_RD > 1) ? $clog2(N_RD) : 1;
    localparam int BEAT_W   = $clog2(LINE_WORDS);

    typedef enum logic {AR_IDLE, AR_VALID} ar_state_t;
    typedef enum logic [1:0] {W_IDLE, W_SEND, W_RESP} w_state_t;

    ar_state_t                 r_ar_state, w_ar_next;
    w_state_t                  r_w_state, w_w_next;
    logic                      r_active;
    logic [N_RD-1:0]           r_busy;
    logic [N_RD-1:0]           w_elig, w_busy_set;
    logic [PTR_W-1:0]          r_ptr, w_grant_idx;
    logic [PTR_W:0]            w_rr_sum;
    logic                      w_grant_found;
    logic [2:0]                w_g_type;
    logic [31:0]               w_g_addr;
    logic [3:0]                r_arid;
    logic [31:0]               r_araddr;
    logic [7:0]                r_arlen;
    logic [2:0]                r_arsize;
    logic [32*LINE_WORDS-1:0]  r_wbuf;
    logic [31:0]               r_wbuf_addr;
    logic [2:0]                r_wtype;
    logic [3:0]                r_wstrb;
    logic                      r_awvalid, r_wvalid, r_wlast;
    logic [BEAT_W-1:0]         r_beat;
    logic                      w_pending, w_aw_done, w_w_done, w_wr_accept;
    logic                      w_unused;

    assign w_unused = ^{rresp, bid, bresp};
    assign w_pending = (r_w_state != W_IDLE);

    // A read stalls only if it falls in the line held by the write buffer.
    always_comb begin
        for (int i = 0; i < N_RD; i++) begin
            w_elig[i] = r_active && rd_req[i] && !r_busy[i] && (r_ar_state == AR_IDLE)
                        && !(w_pending && (rd_addr[i*32+OFFSET_W +: 32-OFFSET_W] == r_wbuf_addr[31:OFFSET_W]));
        end
    end

    always_comb begin
        w_grant_found = 1'b0;
        w_grant_idx   = '0;
        w_rr_sum      = '0;
        for (int k = 0; k < N_RD; k++) begin
            w_rr_sum = {1'b0, r_ptr} + (PTR_W+1)'(k);
            if (w_rr_sum >= (PTR_W+1)'(N_RD)) begin
                w_rr_sum = w_rr_sum - (PTR_W+1)'(N_RD);
            end
            if (!w_grant_found && w_elig[w_rr_sum[PTR_W-1:0]]) begin
                w_grant_found = 1'b1;
                w_grant_idx   = w_rr_sum[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        w_g_type = '0;
        w_g_addr = '0;
        for (int i = 0; i < N_RD; i++) begin
            rd_rdy[i] = w_grant_found && (w_grant_idx == PTR_W'(i));
            if (w_grant_idx == PTR_W'(i)) begin
                w_g_type = rd_type[i*3 +: 3];
                w_g_addr = rd_addr[i*32 +: 32];
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ar_state <= AR_IDLE;
        end else begin
            r_ar_state <= w_ar_next;
        end
    end

    always_comb begin
        w_ar_next = r_ar_state;
        case (r_ar_state)
            AR_IDLE:  if (w_grant_found) w_ar_next = AR_VALID;
            AR_VALID: if (arready)       w_ar_next = AR_IDLE;
            default:  w_ar_next = AR_IDLE;
        endcase
    end

    always_comb begin
        for (int i = 0; i < N_RD; i++) begin
            w_busy_set[i] = (r_ar_state == AR_VALID) && arready && (r_arid == 4'(i));
            ret_valid[i]  = rvalid && r_active && (rid == 4'(i));
            ret_last[i]   = ret_valid[i] && rlast;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_active <= 1'b0;
            r_busy   <= '0;
            r_ptr    <= '0;
            r_arid   <= '0;
            r_araddr <= '0;
            r_arlen  <= '0;
            r_arsize <= '0;
        end else begin
            r_active <= 1'b1;
            // Clear wins over set so a same-cycle return frees the client.
            r_busy   <= (r_busy | w_busy_set) & ~ret_last;
            if (r_ar_state == AR_IDLE && w_grant_found) begin
                r_arid   <= 4'(w_grant_idx);
                r_araddr <= w_g_addr;
                if (w_g_type[2]) begin
                    r_arlen  <= 8'(LINE_WORDS - 1);
                    r_arsize <= 3'b010;
                end else begin
                    r_arlen  <= 8'd0;
                    r_arsize <= w_g_type;
                end
            end
            if (r_ar_state == AR_VALID && arready) begin
                r_ptr <= (r_arid[PTR_W-1:0] == PTR_W'(N_RD - 1)) ? '0 : r_arid[PTR_W-1:0] + 1'b1;
            end
        end
    end

    assign arid     = r_arid;
    assign araddr   = r_araddr;
    assign arlen    = r_arlen;
    assign arsize   = r_arsize;
    assign arburst  = 2'b01;
    assign arlock   = 2'b00;
    assign arcache  = 4'b0000;
    assign arprot   = 3'b000;
    assign arvalid  = (r_ar_state == AR_VALID);
    assign rready   = r_active;
    assign ret_data = rdata;

    assign wr_rdy      = r_active && (r_w_state == W_IDLE);
    assign w_wr_accept = wr_req && wr_rdy;
    assign w_aw_done   = !r_awvalid || awready;
    assign w_w_done    = !r_wvalid || (wready && r_wlast);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_w_state <= W_IDLE;
        end else begin
            r_w_state <= w_w_next;
        end
    end

    always_comb begin
        w_w_next = r_w_state;
        case (r_w_state)
            W_IDLE:  if (w_wr_accept)            w_w_next = W_SEND;
            W_SEND:  if (w_aw_done && w_w_done)  w_w_next = W_RESP;
            W_RESP:  if (bvalid)                 w_w_next = W_IDLE;
            default: w_w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wbuf      <= '0;
            r_wbuf_addr <= '0;
            r_wtype     <= '0;
            r_wstrb     <= '0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_wlast     <= 1'b0;
            r_beat      <= '0;
        end else if (r_w_state == W_IDLE) begin
            if (w_wr_accept) begin
                r_wbuf      <= wr_data;
                r_wbuf_addr <= wr_addr;
                r_wtype     <= wr_type;
                r_wstrb     <= wr_type[2] ? 4'hF : wr_wstrb;
                r_awvalid   <= 1'b1;
                r_wvalid    <= 1'b1;
                r_wlast     <= !wr_type[2];
                r_beat      <= '0;
            end
        end else if (r_w_state == W_SEND) begin
            if (r_awvalid && awready) begin
                r_awvalid <= 1'b0;
            end
            if (r_wvalid && wready) begin
                if (r_wlast) begin
                    r_wvalid <= 1'b0;
                    r_wlast  <= 1'b0;
                end else begin
                    r_wbuf  <= r_wbuf >> 32;
                    r_beat  <= r_beat + 1'b1;
                    r_wlast <= (r_beat == BEAT_W'(LINE_WORDS - 2));
                end
            end
        end
    end

    assign awid    = WR_ID;
    assign awaddr  = r_wbuf_addr;
    assign awlen   = r_wtype[2] ? 8'(LINE_WORDS - 1) : 8'd0;
    assign awsize  = r_wtype[2] ? 3'b010 : r_wtype;
    assign awburst = 2'b01;
    assign awlock  = 2'b00;
    assign awcache = 4'b0000;
    assign awprot  = 3'b000;
    assign awvalid = r_awvalid;
    assign wid     = WR_ID;
    assign wdata   = r_wbuf[31:0];
    assign wstrb   = r_wstrb;
    assign wlast   = r_wlast;
    assign wvalid  = r_wvalid;
    assign bready  = (r_w_state == W_RESP);

    assign write_buffer_empty = !w_pending;

endmodule

// File: tb/tb_axi_bridge_mp.sv
// tb/tb_axi_bridge_mp.sv - directed self-checking bench for axi_bridge_mp
module tb_axi_bridge_mp;

    logic         clk, resetn;
    logic [3:0]   arid, awid, wid, rid, bid;
    logic [31:0]  araddr, awaddr, wdata, rdata, ret_data, wr_addr;
    logic [7:0]   arlen, awlen;
    logic [2:0]   arsize, awsize, arprot, awprot, wr_type;
    logic [1:0]   arburst, arlock, awburst, awlock, rresp, bresp;
    logic [3:0]   arcache, awcache, wstrb, wr_wstrb;
    logic         arvalid, arready, rlast, rvalid, rready;
    logic         awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic [2:0]   rd_req, rd_rdy, ret_valid, ret_last;
    logic [8:0]   rd_type;
    logic [95:0]  rd_addr;
    logic [255:0] wr_data;
    logic         wr_req, wr_rdy, write_buffer_empty;

    int n_tests = 0;
    int n_fail  = 0;

    axi_bridge_mp #(.N_RD(3), .LINE_WORDS(8), .WR_ID(4'hF)) dut (
        .clk(clk), .resetn(resetn),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
        .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
        .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr), .wr_wstrb(wr_wstrb),
        .wr_data(wr_data), .wr_rdy(wr_rdy), .write_buffer_empty(write_buffer_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic fill(input logic [31:0] base);
        for (int k = 0; k < 8; k++) wr_data[k*32 +: 32] = base + 32'(k);
    endtask

    task automatic write_line(input logic [31:0] addr, input logic [31:0] base, input int aw_delay);
        int   beat;
        logic aw_done, got_resp;
        chk("wr_rdy_idle", 32'(wr_rdy), 32'd1);
        wr_req = 1'b1; wr_type = 3'b100; wr_addr = addr; fill(base);
        wready = 1'b1; awready = 1'b0;
        @(negedge clk);
        wr_req = 1'b0;
        chk("wbe_pending", 32'(write_buffer_empty), 32'd0);
        beat = 0; aw_done = 1'b0; got_resp = 1'b0;
        for (int c = 0; c < 40 && !got_resp; c++) begin
            if (bready) begin
                got_resp = 1'b1;
                chk("resp_after_aw", 32'(aw_done), 32'd1);
                chk("resp_beats", 32'(beat), 32'd8);
            end else begin
                awready = (c >= aw_delay);
                if (wvalid) begin
                    chk("wdata", wdata, base + 32'(beat));
                    chk("wlast", 32'(wlast), 32'(beat == 7));
                    chk("wstrb", 32'(wstrb), 32'hF);
                    beat++;
                end
                if (awvalid && awready) begin
                    chk("awaddr", awaddr, addr);
                    chk("awlen", 32'(awlen), 32'd7);
                    chk("awsize", 32'(awsize), 32'd2);
                    chk("awid", 32'(awid), 32'hF);
                    if (aw_delay > 7) chk("w_before_aw", 32'(beat), 32'd8);
                    aw_done = 1'b1;
                end
                @(negedge clk);
            end
        end
        if (!got_resp) chk("bready_timeout", 32'd0, 32'd1);
        awready = 1'b0;
    endtask

    task automatic b_resp();
        chk("bready", 32'(bready), 32'd1);
        bvalid = 1'b1;
        @(negedge clk);
        bvalid = 1'b0;
        chk("bready_drop", 32'(bready), 32'd0);
        chk("wbe_after_b", 32'(write_buffer_empty), 32'd1);
    endtask

    task automatic ar_step(input int g, input logic [31:0] a, input logic [7:0] len, input logic [2:0] sz);
        #1;
        chk("rd_rdy_grant", 32'(rd_rdy), 32'(3'b001 << g));
        @(negedge clk);
        chk("arvalid", 32'(arvalid), 32'd1);
        chk("arid", 32'(arid), 32'(g));
        chk("araddr", araddr, a);
        chk("arlen", 32'(arlen), 32'(len));
        chk("arsize", 32'(arsize), 32'(sz));
        chk("arburst", 32'(arburst), 32'd1);
        rd_req[g] = 1'b0;
        #1;
        chk("rd_rdy_busy_ar", 32'(rd_rdy), 32'd0);
        @(negedge clk);
        chk("arvalid_drop", 32'(arvalid), 32'd0);
    endtask

    task automatic r_beat(input logic [3:0] id, input logic [31:0] d, input logic last, input logic [2:0] exp);
        rid = id; rdata = d; rlast = last; rvalid = 1'b1;
        #1;
        chk("ret_valid", 32'(ret_valid), 32'(exp));
        chk("ret_last", 32'(ret_last), last ? 32'(exp) : 32'd0);
        if (exp != 3'b000) chk("ret_data", ret_data, d);
        @(negedge clk);
        rvalid = 1'b0; rlast = 1'b0;
    endtask

    task automatic probe(input logic [2:0] m, input logic [2:0] exp);
        rd_req = m;
        #1;
        chk("rd_rdy_probe", 32'(rd_rdy), 32'(exp));
        rd_req = 3'b000;
    endtask

    initial begin
        resetn = 1'b0; arready = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
        awready = 1'b0; wready = 1'b0; bid = '0; bresp = '0; bvalid = 1'b0;
        rd_req = 3'b111; rd_type = '0; rd_addr = '0;
        wr_req = 1'b0; wr_type = '0; wr_addr = '0; wr_wstrb = '0; wr_data = '0;
        repeat (2) @(negedge clk);
        chk("rst_valids", 32'({arvalid, awvalid, wvalid, wlast, bready, rready}), 32'd0);
        chk("rst_rd_rdy", 32'(rd_rdy), 32'd0);
        chk("rst_wbe", 32'(write_buffer_empty), 32'd1);
        rd_req = 3'b000;
        resetn = 1'b1;
        @(negedge clk);
        chk("rready_after_rst", 32'(rready), 32'd1);

        // 1: reset during beat 3 of a line write, then a clean write to 0x1000
        wr_type = 3'b100; wr_addr = 32'h4000; fill(32'hA0); wready = 1'b1; awready = 1'b0; wr_req = 1'b1;
        @(negedge clk);
        wr_req = 1'b0;
        chk("t1_awvalid", 32'(awvalid), 32'd1);
        chk("t1_wvalid", 32'(wvalid), 32'd1);
        repeat (3) @(negedge clk);
        chk("t1_beat3", wdata, 32'hA3);
        resetn = 1'b0;
        #1;
        chk("t1_async_drop", 32'({arvalid, awvalid, wvalid, wlast, bready, rready}), 32'd0);
        chk("t1_wbe", 32'(write_buffer_empty), 32'd1);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        write_line(32'h1000, 32'd0, 0);
        b_resp();

        // 2: three clients together, then round-robin after client 0 re-requests
        arready = 1'b1;
        rd_type = {3'b100, 3'b100, 3'b100};
        rd_addr = {32'h300, 32'h200, 32'h100};
        rd_req = 3'b111;
        ar_step(0, 32'h100, 8'd7, 3'd2);
        ar_step(1, 32'h200, 8'd7, 3'd2);
        ar_step(2, 32'h300, 8'd7, 3'd2);
        rd_req = 3'b000;
        r_beat(4'd0, 32'h10, 1'b1, 3'b001);
        r_beat(4'd1, 32'h11, 1'b1, 3'b010);
        r_beat(4'd2, 32'h12, 1'b1, 3'b100);
        rd_req = 3'b111;
        ar_step(0, 32'h100, 8'd7, 3'd2);
        rd_req = 3'b000;
        r_beat(4'd0, 32'h20, 1'b1, 3'b001);
        rd_req = 3'b111;
        ar_step(1, 32'h200, 8'd7, 3'd2);
        ar_step(2, 32'h300, 8'd7, 3'd2);
        ar_step(0, 32'h100, 8'd7, 3'd2);
        rd_req = 3'b000;
        r_beat(4'd0, 32'h30, 1'b1, 3'b001);
        r_beat(4'd1, 32'h31, 1'b1, 3'b010);
        r_beat(4'd2, 32'h32, 1'b1, 3'b100);

        // 3: pending write to line 0x2000 blocks only the same-line read
        write_line(32'h2000, 32'h20, 0);
        rd_type = {3'b100, 3'b010, 3'b010};
        rd_addr = {32'h0, 32'h2010, 32'h3000};
        rd_req = 3'b011;
        ar_step(0, 32'h3000, 8'd0, 3'd2);
        chk("t3_hazard", 32'(rd_rdy), 32'd0);
        chk("t3_wbe", 32'(write_buffer_empty), 32'd0);
        bvalid = 1'b1;
        #1;
        chk("t3_hazard_b", 32'(rd_rdy), 32'd0);
        @(negedge clk);
        bvalid = 1'b0;
        ar_step(1, 32'h2010, 8'd0, 3'd2);
        rd_req = 3'b000;
        r_beat(4'd0, 32'h33, 1'b1, 3'b001);
        r_beat(4'd1, 32'h22, 1'b1, 3'b010);

        // 4: AW held off until the W burst is finished
        write_line(32'h7000, 32'h70, 10);
        b_resp();

        // 5: interleaved returns for clients 0 and 2, plus a stray id
        rd_type = {3'b100, 3'b000, 3'b100};
        rd_addr = {32'h6000, 32'h0, 32'h5000};
        rd_req = 3'b101;
        ar_step(2, 32'h6000, 8'd7, 3'd2);
        ar_step(0, 32'h5000, 8'd7, 3'd2);
        rd_req = 3'b000;
        for (int k = 0; k < 7; k++) begin
            r_beat(4'd0, 32'h500 + 32'(k), 1'b0, 3'b001);
            r_beat(4'd2, 32'h600 + 32'(k), 1'b0, 3'b100);
            if (k == 3) r_beat(4'd5, 32'hDEAD, 1'b0, 3'b000);
        end
        probe(3'b101, 3'b000);
        r_beat(4'd0, 32'h507, 1'b1, 3'b001);
        probe(3'b101, 3'b001);
        r_beat(4'd5, 32'hBEEF, 1'b1, 3'b000);
        r_beat(4'd2, 32'h607, 1'b1, 3'b100);
        probe(3'b101, 3'b100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
